crc5_tx_framer: RTL and testbench

Reader-side transmit framer for EPC Gen2 commands protected by CRC-5, such as Query. It accepts a serial payload bit stream from the command builder and forwards each bit to the downlink encoder. While forwarding, it computes CRC-5: preset 5'b01001, polynomial x^5+x^3+1, no inversion. After the last payload bit it appends the 5 CRC bits, MSB first, so that the tag-side CRC-5 check over payload plus CRC ends at 5'b00000.

---
 rtl/crc5_tx_framer.sv | 114 +++++++++++
 tb/tb_crc5_tx_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc5_tx_framer.sv
// Serial transmit framer: forwards payload bits, then appends their CRC-5
// (x^5+x^3+1, preset PRESET, MSB first) behind a one-bit output register.
module crc5_tx_framer #(
  parameter logic [4:0] PRESET = 5'b01001,
  parameter int         LEN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [4:0]       crc_out,
  output logic [LEN_W-1:0] payload_len
);

  // Handshake: a transfer happens on a cycle where valid & ready are both high
  // at posedge clk; valid never depends on ready, and in_ready never depends
  // on in_valid.
  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] crc;
  logic [2:0] k;
  logic       slot_free;
  logic       in_xfer;
  logic       out_xfer;
  logic       fb;
  logic [4:0] crc_upd;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && slot_free;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign fb        = in_bit ^ crc[4];
  assign crc_upd   = {crc[3], crc[2] ^ fb, crc[1], crc[0], fb};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = DATA;
      DATA: if (in_xfer && in_last) state_next = CRC;
      CRC:  if (slot_free && k == 3'd4) state_next = DONE;
      DONE: if (out_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      crc         <= PRESET;
      k           <= 3'd0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      crc_out     <= 5'd0;
      payload_len <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      // A consumed bit empties the slot unless a new bit is loaded below.
      if (out_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          crc <= PRESET;
          if (start) begin
            payload_len <= '0;
            crc_out     <= 5'd0;
          end
        end
        DATA: begin
          if (in_xfer) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            crc       <= crc_upd;
            if (payload_len != '1) payload_len <= payload_len + 1'b1;
            if (in_last) begin
              crc_out <= crc_upd;
              k       <= 3'd0;
            end
          end
        end
        CRC: begin
          if (slot_free) begin
            out_bit   <= crc[4];
            out_valid <= 1'b1;
            out_last  <= (k == 3'd4);
            crc       <= {crc[3:0], 1'b0};
            k         <= k + 3'd1;
          end
        end
        DONE: begin
          if (out_xfer) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc5_tx_framer.sv
// Bench for crc5_tx_framer: directed and randomized frames checked against a
// polynomial-division CRC model and an expected output queue.
module tb_crc5_tx_framer;

  typedef logic bitq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] crc_out;
  logic [7:0] payload_len;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic [1:0] exp_q[$];
  bitq_t      pay_q;
  bitq_t      obs_q;
  logic       held = 1'b0;
  logic       held_bit = 1'b0;
  logic       held_last = 1'b0;
  int         de;

  crc5_tx_framer #(.PRESET(5'b01001), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_bit(in_bit),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .crc_out(crc_out),
    .payload_len(payload_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC register after feeding s from preset 01001 equals the remainder of
  // (S(x)*x^5 + preset*x^n) mod (x^5+x^3+1).
  function automatic logic [4:0] crc_ref(input bitq_t s);
    logic [511:0] v;
    int n;
    v = '0;
    n = s.size();
    for (int i = 0; i < n; i++) v[n + 4 - i] = s[i];
    v[n + 4 -: 5] = v[n + 4 -: 5] ^ 5'b01001;
    for (int i = n + 4; i >= 5; i--)
      if (v[i]) v[i -: 6] = v[i -: 6] ^ 6'b101001;
    return v[4:0];
  endfunction

  // Output monitor: scoreboard of consumed bits plus hold-stability check.
  always @(negedge clk) begin
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_bits", {out_last, out_bit}, {held_last, held_bit});
      end
      if (out_valid && out_ready) begin
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_stream", {out_last, out_bit}, exp_q.pop_front());
        obs_q.push_back(out_bit);
      end
      held = out_valid && !out_ready;
      held_bit = out_bit;
      held_last = out_last;
    end
  end

  task automatic drive(input int n, input int idx, input int in_pct, input int out_pct,
                       input bit noise, input bit hold_last, inout int hold);
    start = noise && ($urandom_range(0, 3) == 0);
    if (idx < n) begin
      in_valid = ($urandom_range(0, 99) < in_pct);
      in_bit = pay_q[idx];
      in_last = (idx == n - 1);
    end else begin
      in_valid = noise && ($urandom_range(0, 1) == 1);
      in_bit = 1'($urandom_range(0, 1));
      in_last = 1'($urandom_range(0, 1));
    end
    out_ready = ($urandom_range(0, 99) < out_pct);
    if (hold_last && out_valid && out_last && hold < 10) begin
      out_ready = 1'b0;
      hold++;
    end
  endtask

  // Runs one frame from pay_q; done_edge counts edges after the start edge.
  task automatic run_frame(input int n, input int in_pct, input int out_pct, input bit noise,
                           input bit hold_last, input int abort_edge, output int done_edge);
    logic [4:0] exp_crc;
    int e, idx, hold, d0;
    logic in_x;
    exp_crc = crc_ref(pay_q);
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pay_q[i]});
    for (int j = 0; j < 5; j++) exp_q.push_back({j == 4, exp_crc[4 - j]});
    d0 = done_cnt;
    done_edge = -1;
    e = 0; idx = 0; hold = 0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = noise; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drive(n, idx, in_pct, out_pct, noise, hold_last, hold);
    while (e < 3000) begin
      @(negedge clk);
      if (done) begin
        done_edge = e;
        start = 1'b0;
        in_valid = 1'b0;
        break;
      end
      in_x = in_valid && in_ready;
      if (hold_last && out_valid && out_last && !out_ready) chk("done_early", done, 0);
      @(posedge clk);
      e++;
      if (in_x) idx++;
      if (e == abort_edge) return;
      #1 drive(n, idx, in_pct, out_pct, noise, hold_last, hold);
    end
    chk("done_seen", done_edge >= 0, 1);
    chk("accepted", idx, n);
    chk("crc_out", crc_out, exp_crc);
    chk("payload_len", payload_len, (n > 255) ? 255 : n);
    chk("busy_end", busy, 0);
    chk("q_drained", exp_q.size(), 0);
    chk("residue", crc_ref(obs_q), 0);
    @(negedge clk);
    @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic load_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(1'($urandom_range(0, 1)));
  endtask

  initial begin
    int n;
    logic [7:0] plen;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {out_valid, out_bit, out_last, busy, done, in_ready}, 0);
    chk("rst_regs", {crc_out, payload_len}, 0);
    reset = 1'b1;

    // Query code 1000
    pay_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(4, 100, 100, 0, 0, 0, de);
    chk("query_crc", crc_out, 5'b00111);
    chk("query_done_edge", de, 10);

    pay_q = '{1'b1};
    run_frame(1, 100, 100, 0, 0, 0, de);
    chk("one_crc", crc_out, 5'b11011);
    pay_q = '{1'b0};
    run_frame(1, 100, 100, 0, 0, 0, de);
    chk("zero_crc", crc_out, 5'b10010);
    chk("zero_done_edge", de, 7);

    // in_valid in IDLE is ignored
    plen = payload_len;
    @(posedge clk); #1;
    in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_len", payload_len, plen);
    chk("idle_busy", busy, 0);

    // random frames with stalls, odd frames also inject start/in_valid noise
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 40);
      load_payload(n);
      run_frame(n, 70, 65, f[0], 0, 0, de);
    end

    // saturating payload counter
    load_payload(260);
    run_frame(260, 100, 100, 0, 0, 0, de);

    // reset after two CRC bits have been consumed
    pay_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(4, 100, 100, 0, 0, 7, de);
    #1;
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    chk("abort_consumed", obs_q.size(), 6);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_state", {out_valid, busy, done, out_last, out_bit}, 0);
    chk("abort_regs", {crc_out, payload_len}, 0);
    reset = 1'b1;
    pay_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(4, 100, 100, 0, 0, 0, de);
    chk("reframe_crc", crc_out, 5'b00111);
    chk("reframe_done_edge", de, 10);

    // backpressure for 10 cycles on the out_last bit
    pay_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(4, 100, 100, 0, 1, 0, de);
    chk("hold_done_edge", de, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
